// File: rtl/memory_frontend.sv
// Load/store frontend: splits byte-addressed RISC-V loads/stores into backend word reads/writes.
// Latency: error 0 extra edges, SW 1, loads 2, SB/SH 3 (read-modify-write) edges to respValid.
// Backpressure: reqReady is high only in IDLE; one request in flight, none queued.
module memory_frontend (
   input  logic        clock,
   input  logic        reset,
   input  logic        reqValid,
   output logic        reqReady,
   input  logic        reqWrite,
   input  logic [2:0]  reqFunct3,
   input  logic [31:0] reqAddress,
   input  logic [31:0] reqWriteData,
   output logic        respValid,
   output logic [31:0] respData,
   output logic        respError,
   output logic [29:0] backendAddress,
   input  logic [31:0] backendDataOut,
   output logic [31:0] backendDataIn,
   output logic        backendWriteEnable
);

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_WRITE} state_t;

   state_t      r_state;
   state_t      w_next;
   logic [2:0]  r_funct3;
   logic [1:0]  r_offset;
   logic [15:0] r_wdata;
   logic        r_write;
   logic        r_resp_vld;
   logic        r_resp_err;
   logic [31:0] r_resp_dat;
   logic [29:0] r_be_addr;
   logic [31:0] r_be_din;
   logic        r_be_we;

   logic        w_accept;
   logic        w_error;
   logic        w_is_sw;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load;
   logic [31:0] w_merged;

   assign reqReady           = (r_state == S_IDLE);
   assign respValid          = r_resp_vld;
   assign respError          = r_resp_err;
   assign respData           = r_resp_dat;
   assign backendAddress     = r_be_addr;
   assign backendDataIn      = r_be_din;
   assign backendWriteEnable = r_be_we;

   assign w_accept = reqValid && (r_state == S_IDLE);
   assign w_is_sw  = reqWrite && (reqFunct3 == 3'b010);

   // Classify the incoming request as misaligned or illegal funct3
   always_comb begin
      w_error = 1'b1;
      if (reqWrite) begin
         case (reqFunct3)
            3'b000:  w_error = 1'b0;
            3'b001:  w_error = reqAddress[0];
            3'b010:  w_error = (reqAddress[1:0] != 2'b00);
            default: w_error = 1'b1;
         endcase
      end else begin
         case (reqFunct3)
            3'b000, 3'b100: w_error = 1'b0;
            3'b001, 3'b101: w_error = reqAddress[0];
            3'b010:         w_error = (reqAddress[1:0] != 2'b00);
            default:        w_error = 1'b1;
         endcase
      end
   end

   // Lane selection from the returned word; little-endian byte lanes
   assign w_byte = backendDataOut[{r_offset, 3'b000} +: 8];
   assign w_half = r_offset[1] ? backendDataOut[31:16] : backendDataOut[15:0];

   // Extend the selected lane; funct3[2] marks the unsigned variants
   always_comb begin
      w_load = backendDataOut;
      case (r_funct3[1:0])
         2'b00:   w_load = {{24{w_byte[7] & ~r_funct3[2]}}, w_byte};
         2'b01:   w_load = {{16{w_half[15] & ~r_funct3[2]}}, w_half};
         default: w_load = backendDataOut;
      endcase
   end

   // Merge the store byte/halfword into the old word, keeping other lanes
   always_comb begin
      w_merged = backendDataOut;
      if (r_funct3[0] == 1'b0) begin
         w_merged[{r_offset, 3'b000} +: 8] = r_wdata[7:0];
      end else if (r_offset[1]) begin
         w_merged[31:16] = r_wdata;
      end else begin
         w_merged[15:0] = r_wdata;
      end
   end

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state: SW skips the read, sub-word stores read then write
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept && !w_error) begin
               w_next = w_is_sw ? S_WRITE : S_ADDR;
            end
         end
         S_ADDR:  w_next = S_DATA;
         S_DATA:  w_next = r_write ? S_WRITE : S_IDLE;
         S_WRITE: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Request latching, backend drive and response generation
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_funct3   <= 3'b000;
         r_offset   <= 2'b00;
         r_wdata    <= 16'h0000;
         r_write    <= 1'b0;
         r_resp_vld <= 1'b0;
         r_resp_err <= 1'b0;
         r_resp_dat <= 32'h0;
         r_be_addr  <= 30'h0;
         r_be_din   <= 32'h0;
         r_be_we    <= 1'b0;
      end else begin
         r_resp_vld <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_funct3 <= reqFunct3;
                  r_offset <= reqAddress[1:0];
                  r_wdata  <= reqWriteData[15:0];
                  r_write  <= reqWrite;
                  if (w_error) begin
                     // Rejected requests never touch the backend
                     r_resp_vld <= 1'b1;
                     r_resp_err <= 1'b1;
                     r_resp_dat <= 32'h0;
                  end else begin
                     r_be_addr <= reqAddress[31:2];
                     if (w_is_sw) begin
                        r_be_din <= reqWriteData;
                        r_be_we  <= 1'b1;
                     end
                  end
               end
            end
            S_DATA: begin
               if (r_write) begin
                  r_be_din <= w_merged;
                  r_be_we  <= 1'b1;
               end else begin
                  r_resp_vld <= 1'b1;
                  r_resp_err <= 1'b0;
                  r_resp_dat <= w_load;
               end
            end
            S_WRITE: begin
               r_be_we    <= 1'b0;
               r_resp_vld <= 1'b1;
               r_resp_err <= 1'b0;
               r_resp_dat <= 32'h0;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_memory_frontend.sv
// Directed bench for memory_frontend with a word-addressed backend memory model.
// Latency: checks respValid timing per request class against hand-derived values.
// Backpressure: requests are only issued when reqReady is sampled high.
module tb_memory_frontend;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        reqValid = 1'b0;
   logic        reqReady;
   logic        reqWrite = 1'b0;
   logic [2:0]  reqFunct3 = 3'b000;
   logic [31:0] reqAddress = 32'h0;
   logic [31:0] reqWriteData = 32'h0;
   logic        respValid;
   logic [31:0] respData;
   logic        respError;
   logic [29:0] backendAddress;
   logic [31:0] backendDataOut = 32'h0;
   logic [31:0] backendDataIn;
   logic        backendWriteEnable;

   logic [31:0] mem [0:255];

   int checks = 0;
   int failures = 0;
   logic [29:0] exp_ba = 30'h0;

   typedef struct {
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wd;
      logic        err;
      logic [31:0] data;
      int          lat;
   } vec_t;

   vec_t vt [0:19];

   memory_frontend dut (
      .clock              (clock),
      .reset              (reset),
      .reqValid           (reqValid),
      .reqReady           (reqReady),
      .reqWrite           (reqWrite),
      .reqFunct3          (reqFunct3),
      .reqAddress         (reqAddress),
      .reqWriteData       (reqWriteData),
      .respValid          (respValid),
      .respData           (respData),
      .respError          (respError),
      .backendAddress     (backendAddress),
      .backendDataOut     (backendDataOut),
      .backendDataIn      (backendDataIn),
      .backendWriteEnable (backendWriteEnable)
   );

   always #5 clock = ~clock;

   // Synchronous-read, write-at-edge backend memory
   always @(posedge clock) begin
      if (backendWriteEnable) mem[backendAddress[7:0]] <= backendDataIn;
      backendDataOut <= mem[backendAddress[7:0]];
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   // Issue one request at the current sample point and follow it to its response
   task automatic run_vec(input int idx, input vec_t v);
      int n;
      int we_cnt;
      string tag;
      tag = $sformatf("v%0d", idx);
      check({tag, "_ready"}, {31'h0, reqReady}, 32'h1);
      reqValid     = 1'b1;
      reqWrite     = v.wr;
      reqFunct3    = v.f3;
      reqAddress   = v.addr;
      reqWriteData = v.wd;
      @(posedge clock);
      #1;
      reqValid = 1'b0;
      if (!v.err) exp_ba = v.addr[31:2];
      check({tag, "_baddr"}, {2'b00, backendAddress}, {2'b00, exp_ba});
      if (v.lat > 0) check({tag, "_busy"}, {31'h0, reqReady}, 32'h0);
      n = 0;
      we_cnt = 0;
      while (respValid !== 1'b1 && n < 8) begin
         if (backendWriteEnable) we_cnt++;
         @(posedge clock);
         #1;
         n++;
      end
      if (backendWriteEnable) we_cnt++;
      check({tag, "_latency"}, n, v.lat);
      check({tag, "_error"}, {31'h0, respError}, {31'h0, v.err});
      check({tag, "_data"}, respData, v.data);
      check({tag, "_we_cycles"}, we_cnt, (v.wr && !v.err) ? 1 : 0);
   endtask

   initial begin
      int n;
      int seen;

      vt[0]  = '{1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 1'b0, 32'h0,        1};
      vt[1]  = '{1'b1, 3'b000, 32'h105, 32'h123456AA, 1'b0, 32'h0,        3};
      vt[2]  = '{1'b0, 3'b000, 32'h105, 32'h0,        1'b0, 32'hFFFFFFAA, 2};
      vt[3]  = '{1'b0, 3'b100, 32'h105, 32'h0,        1'b0, 32'h000000AA, 2};
      vt[4]  = '{1'b0, 3'b001, 32'h106, 32'h0,        1'b0, 32'hFFFFDEAD, 2};
      vt[5]  = '{1'b0, 3'b101, 32'h106, 32'h0,        1'b0, 32'h0000DEAD, 2};
      vt[6]  = '{1'b0, 3'b010, 32'h104, 32'h0,        1'b0, 32'hDEADAAEF, 2};
      vt[7]  = '{1'b0, 3'b010, 32'h102, 32'h0,        1'b1, 32'h0,        0};
      vt[8]  = '{1'b1, 3'b011, 32'h200, 32'h11111111, 1'b1, 32'h0,        0};
      vt[9]  = '{1'b0, 3'b001, 32'h305, 32'h0,        1'b1, 32'h0,        0};
      vt[10] = '{1'b0, 3'b110, 32'h400, 32'h0,        1'b1, 32'h0,        0};
      vt[11] = '{1'b1, 3'b001, 32'h106, 32'hABCD1234, 1'b0, 32'h0,        3};
      vt[12] = '{1'b0, 3'b010, 32'h104, 32'h0,        1'b0, 32'h1234AAEF, 2};
      vt[13] = '{1'b0, 3'b000, 32'h104, 32'h0,        1'b0, 32'hFFFFFFEF, 2};
      vt[14] = '{1'b0, 3'b100, 32'h107, 32'h0,        1'b0, 32'h00000012, 2};
      vt[15] = '{1'b1, 3'b000, 32'h107, 32'h00000080, 1'b0, 32'h0,        3};
      vt[16] = '{1'b0, 3'b000, 32'h107, 32'h0,        1'b0, 32'hFFFFFF80, 2};
      vt[17] = '{1'b1, 3'b001, 32'h104, 32'h0000FFFF, 1'b0, 32'h0,        3};
      vt[18] = '{1'b0, 3'b101, 32'h104, 32'h0,        1'b0, 32'h0000FFFF, 2};
      vt[19] = '{1'b0, 3'b001, 32'h104, 32'h0,        1'b0, 32'hFFFFFFFF, 2};

      // Power-on reset values
      repeat (2) @(posedge clock);
      #1;
      check("rst_ready", {31'h0, reqReady}, 32'h1);
      check("rst_resp_vld", {31'h0, respValid}, 32'h0);
      check("rst_resp_err", {31'h0, respError}, 32'h0);
      check("rst_resp_data", respData, 32'h0);
      check("rst_baddr", {2'b00, backendAddress}, 32'h0);
      check("rst_bdin", backendDataIn, 32'h0);
      check("rst_we", {31'h0, backendWriteEnable}, 32'h0);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      check("idle_no_resp", {31'h0, respValid}, 32'h0);

      // SW, SB RMW, loads and error cases, issued back-to-back
      for (int i = 0; i <= 10; i++) run_vec(i, vt[i]);
      check("mem_after_sb", mem[8'h41], 32'hDEADAAEF);

      // Pulse width: respValid must drop one cycle after the last error response
      @(posedge clock);
      #1;
      check("resp_single_pulse", {31'h0, respValid}, 32'h0);

      // SH whose WRITE cycle is cut by an asynchronous reset
      reqValid     = 1'b1;
      reqWrite     = 1'b1;
      reqFunct3    = 3'b001;
      reqAddress   = 32'h104;
      reqWriteData = 32'h00005555;
      @(posedge clock);
      #1;
      reqValid = 1'b0;
      n = 0;
      while (backendWriteEnable !== 1'b1 && n < 8) begin
         @(posedge clock);
         #1;
         n++;
      end
      check("sh_we_edge", n, 2);
      check("sh_merged", backendDataIn, 32'hDEAD5555);
      reset = 1'b0;
      #1;
      check("mid_rst_we", {31'h0, backendWriteEnable}, 32'h0);
      check("mid_rst_ready", {31'h0, reqReady}, 32'h1);
      check("mid_rst_resp_vld", {31'h0, respValid}, 32'h0);
      check("mid_rst_baddr", {2'b00, backendAddress}, 32'h0);
      check("mid_rst_bdin", backendDataIn, 32'h0);
      check("mid_rst_resp_data", respData, 32'h0);
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      exp_ba = 30'h0;
      seen = 0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clock);
         #1;
         if (respValid) seen++;
      end
      check("post_rst_no_resp", seen, 0);
      check("post_rst_ready", {31'h0, reqReady}, 32'h1);
      check("mem_unchanged", mem[8'h41], 32'hDEADAAEF);

      // SH, more loads, SB to the top lane, SH to the low half
      for (int i = 11; i <= 19; i++) run_vec(i, vt[i]);
      check("mem_final", mem[8'h41], 32'h8034FFFF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
